// File: rtl/ready_packets_fifo_pkg.sv
// Shared constants for the ready-packets byte FIFO and its transport-level users.
package ready_packets_fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_ADDR_W = 10;
    localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;

    // Encoding is {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/ready_packets_ram.sv
// Simple dual-port RAM: one synchronous write port and one synchronous registered read port.
import ready_packets_fifo_pkg::*;

module ready_packets_ram #(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_srst,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic              i_rdEn,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdData;

    // The array carries no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    always_ff @(posedge i_clk or posedge i_srst) begin
        if (i_srst) begin
            r_rdData <= '0;
        end else if (i_rdEn) begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/ready_packets_fifo.sv
// Byte FIFO buffering received packet bytes until the transport receiver drains them.
import ready_packets_fifo_pkg::*;

module ready_packets_fifo #(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   data_count
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_count;
    logic              r_empty;
    logic              r_full;

    logic              w_wrAccept;
    logic              w_rdAccept;
    fifo_op_e          w_op;
    logic [ADDR_W:0]   w_countNext;
    logic [DATA_W-1:0] w_ramData;

    // Registered flags gate acceptance, so a full FIFO never overwrites and an empty one never reads.
    assign w_wrAccept = wr_en && !r_full;
    assign w_rdAccept = rd_en && !r_empty;
    assign w_op       = fifo_op_e'({w_wrAccept, w_rdAccept});

    always_comb begin
        w_countNext = r_count;
        case (w_op)
            OP_WRITE: w_countNext = r_count + CNT_ONE;
            OP_READ:  w_countNext = r_count - CNT_ONE;
            default:  w_countNext = r_count;
        endcase
    end

    // Flags come from the next count so they update on the same edge as the operation.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_rdAccept) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            r_count <= w_countNext;
            r_empty <= (w_countNext == '0);
            r_full  <= (w_countNext == CNT_FULL);
        end
    end

    ready_packets_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk    (clk),
        .i_srst   (srst),
        .i_wrEn   (w_wrAccept),
        .i_wrAddr (r_wrPtr),
        .i_wrData (din),
        .i_rdEn   (w_rdAccept),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_ramData)
    );

    assign dout       = w_ramData;
    assign empty      = r_empty;
    assign full       = r_full;
    assign data_count = r_count;

endmodule

// File: tb/tb_ready_packets_fifo.sv
// Directed checks of the ready-packets FIFO with hand-computed expected values.
module tb_ready_packets_fifo;

    logic        clk;
    logic        srst;
    logic [7:0]  din;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  dout;
    logic        empty;
    logic        full;
    logic [10:0] data_count;

    int nAsserts = 0;
    int nFails   = 0;

    ready_packets_fifo dut (
        .clk        (clk),
        .srst       (srst),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .empty      (empty),
        .full       (full),
        .data_count (data_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then settle 1 time unit past the edge before anyone samples.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] d);
        wr_en = wr;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkFlags(input string tag, input int cnt, input logic e, input logic f);
        checkOutput({tag, " count"}, 32'(data_count), 32'(cnt));
        checkOutput({tag, " empty"}, 32'(empty), 32'(e));
        checkOutput({tag, " full"},  32'(full),  32'(f));
    endtask

    initial begin
        logic [7:0] pattern16 [16];

        srst  = 1'b1;
        din   = 8'h00;
        wr_en = 1'b0;
        rd_en = 1'b0;

        // 1. reset and idle, then an asynchronous mid-cycle reset
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        checkFlags("reset", 0, 1'b1, 1'b0);
        checkOutput("reset dout", 32'(dout), 32'h00);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
        checkFlags("idle", 0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h5A);
        checkFlags("pre-async wr", 1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("pre-async dout", 32'(dout), 32'h5A);
        applyStimulus(1'b1, 1'b0, 8'h3C);
        applyStimulus(1'b0, 1'b0, 8'h00);
        #2 srst = 1'b1;
        #1;
        checkFlags("async reset", 0, 1'b1, 1'b0);
        checkOutput("async reset dout", 32'(dout), 32'h00);
        @(posedge clk);
        #1 srst = 1'b0;

        // 2. sixteen bytes in, sixteen out, in order
        pattern16[0] = 8'h40;
        for (int i = 1; i < 16; i++) pattern16[i] = 8'(i);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, pattern16[i]);
        checkFlags("wr16", 16, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checkOutput("rd16 dout", 32'(dout), 32'(pattern16[i]));
            checkOutput("rd16 count", 32'(data_count), 32'(15 - i));
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkFlags("rd16 done", 0, 1'b1, 1'b0);

        // 3. fill to 1024, overflow byte dropped, drain everything
        for (int i = 0; i < 1024; i++) applyStimulus(1'b1, 1'b0, 8'(i % 256));
        checkFlags("fill", 1024, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'hAA);
        checkFlags("overflow", 1024, 1'b0, 1'b1);
        for (int i = 0; i < 1024; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checkOutput("drain dout", 32'(dout), 32'(i % 256));
        end
        checkOutput("drain last", 32'(dout), 32'hFF);
        checkFlags("drained", 0, 1'b1, 1'b0);

        // 4. reads on empty are ignored; simultaneous rd/wr on empty only writes
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checkOutput("underflow count", 32'(data_count), 32'd0);
            checkOutput("underflow dout", 32'(dout), 32'hFF);
        end
        applyStimulus(1'b1, 1'b1, 8'h55);
        checkFlags("empty rdwr", 1, 1'b0, 1'b0);
        checkOutput("no bypass dout", 32'(dout), 32'hFF);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("empty rdwr dout", 32'(dout), 32'h55);
        checkFlags("empty rdwr after", 0, 1'b1, 1'b0);

        // 5. steady occupancy of 500 across pointer wrap, then rd/wr while full
        for (int i = 0; i < 500; i++) applyStimulus(1'b1, 1'b0, 8'(i % 256));
        checkFlags("hold500 load", 500, 1'b0, 1'b0);
        for (int k = 0; k < 1000; k++) begin
            applyStimulus(1'b1, 1'b1, 8'((500 + k) % 256));
            checkOutput("hold500 dout", 32'(dout), 32'(k % 256));
            checkOutput("hold500 count", 32'(data_count), 32'd500);
        end
        for (int j = 0; j < 500; j++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checkOutput("hold500 drain", 32'(dout), 32'((1000 + j) % 256));
        end
        checkFlags("hold500 empty", 0, 1'b1, 1'b0);
        for (int i = 0; i < 1024; i++) applyStimulus(1'b1, 1'b0, 8'((i + 7) % 256));
        checkFlags("refill", 1024, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h99);
        checkFlags("full rdwr", 1023, 1'b0, 1'b0);
        checkOutput("full rdwr dout", 32'(dout), 32'h07);
        applyStimulus(1'b1, 1'b1, 8'h98);
        checkFlags("nearfull rdwr", 1023, 1'b0, 1'b0);
        checkOutput("nearfull rdwr dout", 32'(dout), 32'h08);

        // 6. reset mid-read discards everything; FIFO works again afterwards
        srst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        srst = 1'b0;
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b0, 8'(i + 8'h20));
        checkFlags("load100", 100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checkOutput("midread dout", 32'(dout), 32'(8'h20 + i));
        end
        #2 srst = 1'b1;
        #1;
        checkFlags("midread reset", 0, 1'b1, 1'b0);
        checkOutput("midread reset dout", 32'(dout), 32'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        srst = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h77);
        checkFlags("post reset wr", 1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("post reset dout", 32'(dout), 32'h77);
        checkFlags("post reset rd", 0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
